// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit computer: opcodes and control-word bit layout.
package cpu_pkg;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JC  = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam int CW_WIDTH = 17;

  localparam int CW_CO  = 0;
  localparam int CW_MI  = 1;
  localparam int CW_RO  = 2;
  localparam int CW_RI  = 3;
  localparam int CW_II  = 4;
  localparam int CW_CE  = 5;
  localparam int CW_IO  = 6;
  localparam int CW_J   = 7;
  localparam int CW_OI  = 8;
  localparam int CW_AI  = 9;
  localparam int CW_BI  = 10;
  localparam int CW_AO  = 11;
  localparam int CW_BO  = 12;
  localparam int CW_EO  = 13;
  localparam int CW_SU  = 14;
  localparam int CW_HLT = 15;
  localparam int CW_FI  = 16;

endpackage

// File: rtl/microcode_rom.sv
// Combinational microcode: (opcode, step, flags) -> control word.
// JC/JZ and the FI flag-load line exist only when CONTROL_UNIT_COND_JUMP_EN is defined.
module microcode_rom
  import cpu_pkg::*;
#(
  parameter int STEPS = 5
) (
  input  logic [3:0]                 opcode_i,
  input  logic [$clog2(STEPS)-1:0]   step_i,
`ifdef CONTROL_UNIT_COND_JUMP_EN
  input  logic                       carry_flag_i,
  input  logic                       zero_flag_i,
`endif
  output logic [CW_WIDTH-1:0]        cw_o
);

  localparam int STEP_W = $clog2(STEPS);
  localparam logic [STEP_W-1:0] T0 = STEP_W'(0);
  localparam logic [STEP_W-1:0] T1 = STEP_W'(1);
  localparam logic [STEP_W-1:0] T2 = STEP_W'(2);
  localparam logic [STEP_W-1:0] T3 = STEP_W'(3);
  localparam logic [STEP_W-1:0] T4 = STEP_W'(4);

  // Steps beyond an instruction's last action fall through to an all-zero word.
  always_comb begin
    cw_o = '0;
    case (step_i)
      T0: begin
        cw_o[CW_CO] = 1'b1;
        cw_o[CW_MI] = 1'b1;
      end
      T1: begin
        cw_o[CW_RO] = 1'b1;
        cw_o[CW_II] = 1'b1;
        cw_o[CW_CE] = 1'b1;
      end
      T2: begin
        case (opcode_i)
          OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
            cw_o[CW_IO] = 1'b1;
            cw_o[CW_MI] = 1'b1;
          end
          OP_LDI: begin
            cw_o[CW_IO] = 1'b1;
            cw_o[CW_AI] = 1'b1;
          end
          OP_JMP: begin
            cw_o[CW_IO] = 1'b1;
            cw_o[CW_J]  = 1'b1;
          end
          OP_OUT: begin
            cw_o[CW_AO] = 1'b1;
            cw_o[CW_OI] = 1'b1;
          end
          OP_HLT: cw_o[CW_HLT] = 1'b1;
`ifdef CONTROL_UNIT_COND_JUMP_EN
          OP_JC: begin
            if (carry_flag_i) begin
              cw_o[CW_IO] = 1'b1;
              cw_o[CW_J]  = 1'b1;
            end else begin
              cw_o = '0;
            end
          end
          OP_JZ: begin
            if (zero_flag_i) begin
              cw_o[CW_IO] = 1'b1;
              cw_o[CW_J]  = 1'b1;
            end else begin
              cw_o = '0;
            end
          end
`endif
          default: cw_o = '0;
        endcase
      end
      T3: begin
        case (opcode_i)
          OP_LDA: begin
            cw_o[CW_RO] = 1'b1;
            cw_o[CW_AI] = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            cw_o[CW_RO] = 1'b1;
            cw_o[CW_BI] = 1'b1;
          end
          OP_STA: begin
            cw_o[CW_AO] = 1'b1;
            cw_o[CW_RI] = 1'b1;
          end
          default: cw_o = '0;
        endcase
      end
      T4: begin
        case (opcode_i)
          OP_ADD, OP_SUB: begin
            cw_o[CW_EO] = 1'b1;
            cw_o[CW_AI] = 1'b1;
            cw_o[CW_SU] = (opcode_i == OP_SUB);
`ifdef CONTROL_UNIT_COND_JUMP_EN
            cw_o[CW_FI] = 1'b1;
`endif
          end
          default: cw_o = '0;
        endcase
      end
      default: cw_o = '0;
    endcase
  end

endmodule

// File: rtl/tri_state_buffer.sv
// Drives data onto a shared bus when enabled, otherwise releases it.
module tri_state_buffer #(
  parameter int WIDTH = 8
) (
  input  logic             en_i,
  input  logic [WIDTH-1:0] data_i,
  inout  wire  [WIDTH-1:0] bus_io
);

  assign bus_io = en_i ? data_i : {WIDTH{1'bz}};

endmodule

// File: rtl/control_unit.sv
// Microcoded control sequencer: owns IR, microstep counter, halt flag and the operand bus driver.
// Optional conditional jumps and flag load are enabled by CONTROL_UNIT_COND_JUMP_EN.
module control_unit
  import cpu_pkg::*;
#(
  parameter int STEPS        = 5,
  parameter int OPERAND_BITS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  inout  wire  [7:0] bus,
`ifdef CONTROL_UNIT_COND_JUMP_EN
  input  logic       carry_flag,
  input  logic       zero_flag,
  output logic       FI,
`endif
  output logic       load_A,
  output logic       load_B,
  output logic       write_A,
  output logic       write_B,
  output logic       write_ALU,
  output logic       subtract,
  output logic       MI,
  output logic       RO,
  output logic       RI,
  output logic       CO,
  output logic       CE,
  output logic       J,
  output logic       OI,
  output logic       halted
);

  localparam int STEP_W = $clog2(STEPS);

  logic [7:0]          ir_q, ir_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic                halted_q, halted_d;
  logic [CW_WIDTH-1:0] rom_cw_s, cw_s;
  logic                advance_s;
  logic                bus_en_s;
  logic [7:0]          operand_s;

  microcode_rom #(.STEPS(STEPS)) u_rom (
    .opcode_i     (ir_q[7:4]),
    .step_i       (step_q),
`ifdef CONTROL_UNIT_COND_JUMP_EN
    .carry_flag_i (carry_flag),
    .zero_flag_i  (zero_flag),
`endif
    .cw_o         (rom_cw_s)
  );

  tri_state_buffer #(.WIDTH(8)) u_bus_drv (
    .en_i   (bus_en_s),
    .data_i (operand_s),
    .bus_io (bus)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      ir_q     <= 8'h00;
      step_q   <= '0;
      halted_q <= 1'b0;
    end else begin
      ir_q     <= ir_d;
      step_q   <= step_d;
      halted_q <= halted_d;
    end
  end

  // Next state: everything holds unless running and not halted
  always_comb begin
    advance_s = run && !halted_q;
    ir_d      = ir_q;
    step_d    = step_q;
    halted_d  = halted_q;
    if (advance_s) begin
      step_d = (step_q == STEP_W'(STEPS - 1)) ? '0 : step_q + STEP_W'(1);
      if (cw_s[CW_II]) begin
        ir_d = bus;
      end else begin
        ir_d = ir_q;
      end
      if (cw_s[CW_HLT]) begin
        halted_d = 1'b1;
      end else begin
        halted_d = halted_q;
      end
    end else begin
      step_d = step_q;
    end
  end

  // Output decode; reset and halt force a quiet control word and a released bus
  always_comb begin
    if (rst || halted_q) begin
      cw_s = '0;
    end else begin
      cw_s = rom_cw_s;
    end
    load_A    = cw_s[CW_AI];
    load_B    = cw_s[CW_BI];
    write_A   = cw_s[CW_AO];
    write_B   = cw_s[CW_BO];
    write_ALU = cw_s[CW_EO];
    subtract  = cw_s[CW_SU];
    MI        = cw_s[CW_MI];
    RO        = cw_s[CW_RO];
    RI        = cw_s[CW_RI];
    CO        = cw_s[CW_CO];
    CE        = cw_s[CW_CE];
    J         = cw_s[CW_J];
    OI        = cw_s[CW_OI];
    halted    = halted_q && !rst;
    bus_en_s  = cw_s[CW_IO];
    operand_s = {{(8 - OPERAND_BITS){1'b0}}, ir_q[OPERAND_BITS-1:0]};
  end

`ifdef CONTROL_UNIT_COND_JUMP_EN
  assign FI = cw_s[CW_FI];
`else
  logic unused_fi_s;
  assign unused_fi_s = cw_s[CW_FI];
`endif

endmodule

// File: tb/tb_control_unit.sv
// Directed self-checking bench for control_unit; adds flag/jump checks when
// CONTROL_UNIT_COND_JUMP_EN is defined.
module tb_control_unit;

  logic       clk;
  logic       rst;
  logic       run;
  logic [7:0] drv;
  logic       drv_en;
  wire  [7:0] bus;
  logic load_A, load_B, write_A, write_B, write_ALU, subtract;
  logic MI, RO, RI, CO, CE, J, OI, halted;
  logic fi_s;
  int   checks;
  int   failures;

`ifdef CONTROL_UNIT_COND_JUMP_EN
  logic carry_flag, zero_flag, FI;
  assign fi_s = FI;
  localparam logic [14:0] K_FIA = 15'h4000;
`else
  assign fi_s = 1'b0;
  localparam logic [14:0] K_FIA = 15'h0000;
`endif

  localparam logic [14:0] K_0   = 15'h0000;
  localparam logic [14:0] K_HLT = 15'h2000;
  localparam logic [14:0] K_CO  = 15'h1000;
  localparam logic [14:0] K_MI  = 15'h0800;
  localparam logic [14:0] K_RO  = 15'h0400;
  localparam logic [14:0] K_RI  = 15'h0200;
  localparam logic [14:0] K_CE  = 15'h0100;
  localparam logic [14:0] K_J   = 15'h0080;
  localparam logic [14:0] K_OI  = 15'h0040;
  localparam logic [14:0] K_AI  = 15'h0020;
  localparam logic [14:0] K_BI  = 15'h0010;
  localparam logic [14:0] K_AO  = 15'h0008;
  localparam logic [14:0] K_EO  = 15'h0002;
  localparam logic [14:0] K_SU  = 15'h0001;

  logic [14:0] ctl;
  assign ctl = {fi_s, halted, CO, MI, RO, RI, CE, J, OI,
                load_A, load_B, write_A, write_B, write_ALU, subtract};

  assign bus = drv_en ? drv : 8'hzz;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  control_unit #(.STEPS(5), .OPERAND_BITS(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .bus        (bus),
`ifdef CONTROL_UNIT_COND_JUMP_EN
    .carry_flag (carry_flag),
    .zero_flag  (zero_flag),
    .FI         (FI),
`endif
    .load_A     (load_A),
    .load_B     (load_B),
    .write_A    (write_A),
    .write_B    (write_B),
    .write_ALU  (write_ALU),
    .subtract   (subtract),
    .MI         (MI),
    .RO         (RO),
    .RI         (RI),
    .CO         (CO),
    .CE         (CE),
    .J          (J),
    .OI         (OI),
    .halted     (halted)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: after the edge set the bench's bus drive, then check controls and bus.
  task automatic cyc(input string tag, input logic [7:0] dval, input logic den,
                     input logic [14:0] ectl, input logic [7:0] ebus);
    @(posedge clk);
    #1;
    drv    = dval;
    drv_en = den;
    #1;
    chk({tag, "_ctl"}, {1'b0, ctl}, {1'b0, ectl});
    chk({tag, "_bus"}, {8'h00, bus}, {8'h00, ebus});
  endtask

  // From T0: advance into T1, present the instruction so IR captures it on the next edge.
  task automatic fetch(input string tag, input logic [7:0] instr);
    cyc({tag, "_t1"}, instr, 1'b1, K_RO | K_CE, instr);
  endtask

  task automatic tail(input string tag);
    cyc({tag, "_t3"}, 8'h00, 1'b1, K_0, 8'h00);
    cyc({tag, "_t4"}, 8'h00, 1'b1, K_0, 8'h00);
    cyc({tag, "_t0"}, 8'h00, 1'b1, K_CO | K_MI, 8'h00);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    run      = 1'b1;
    drv      = 8'h00;
    drv_en   = 1'b1;
`ifdef CONTROL_UNIT_COND_JUMP_EN
    carry_flag = 1'b0;
    zero_flag  = 1'b0;
`endif

    for (int i = 0; i < 3; i++) cyc("reset", 8'h00, 1'b1, K_0, 8'h00);
    rst = 1'b0;
    #1;
    chk("post_reset_t0", {1'b0, ctl}, {1'b0, K_CO | K_MI});

    // LDA 14
    fetch("lda", 8'h1E);
    cyc("lda_t2", 8'h00, 1'b0, K_MI, 8'h0E);
    cyc("lda_t3", 8'h00, 1'b1, K_RO | K_AI, 8'h00);
    cyc("lda_t4", 8'h00, 1'b1, K_0, 8'h00);
    cyc("lda_wrap", 8'h00, 1'b1, K_CO | K_MI, 8'h00);

    // SUB 15
    fetch("sub", 8'h3F);
    cyc("sub_t2", 8'h00, 1'b0, K_MI, 8'h0F);
    cyc("sub_t3", 8'h00, 1'b1, K_RO | K_BI, 8'h00);
    cyc("sub_t4", 8'h00, 1'b1, K_EO | K_AI | K_SU | K_FIA, 8'h00);
    cyc("sub_t0", 8'h00, 1'b1, K_CO | K_MI, 8'h00);

    // ADD 10
    fetch("add", 8'h2A);
    cyc("add_t2", 8'h00, 1'b0, K_MI, 8'h0A);
    cyc("add_t3", 8'h00, 1'b1, K_RO | K_BI, 8'h00);
    cyc("add_t4", 8'h00, 1'b1, K_EO | K_AI | K_FIA, 8'h00);
    cyc("add_t0", 8'h00, 1'b1, K_CO | K_MI, 8'h00);

    // STA 2 with a 4-cycle pause at T2
    fetch("sta", 8'h42);
    cyc("sta_t2", 8'h00, 1'b0, K_MI, 8'h02);
    run = 1'b0;
    for (int i = 0; i < 4; i++) cyc("sta_hold", 8'h00, 1'b0, K_MI, 8'h02);
    run = 1'b1;
    cyc("sta_t3", 8'h00, 1'b1, K_AO | K_RI, 8'h00);
    cyc("sta_t4", 8'h00, 1'b1, K_0, 8'h00);
    cyc("sta_t0", 8'h00, 1'b1, K_CO | K_MI, 8'h00);

    // LDI 7
    fetch("ldi", 8'h57);
    cyc("ldi_t2", 8'h00, 1'b0, K_AI, 8'h07);
    tail("ldi");

    // OUT: A drives the bus, operand must stay off it
    fetch("out", 8'hE3);
    cyc("out_t2", 8'h00, 1'b1, K_AO | K_OI, 8'h00);
    tail("out");

    // Undefined opcode 1001 behaves as NOP
    fetch("nop9", 8'h9C);
    cyc("nop9_t2", 8'h00, 1'b1, K_0, 8'h00);
    tail("nop9");

    // JC/JZ with flags clear (and as NOPs when the feature is absent)
    fetch("jc0", 8'h75);
    cyc("jc0_t2", 8'h00, 1'b1, K_0, 8'h00);
    tail("jc0");
    fetch("jz0", 8'h83);
    cyc("jz0_t2", 8'h00, 1'b1, K_0, 8'h00);
    tail("jz0");

`ifdef CONTROL_UNIT_COND_JUMP_EN
    carry_flag = 1'b1;
    fetch("jc1", 8'h75);
    cyc("jc1_t2", 8'h00, 1'b0, K_J, 8'h05);
    carry_flag = 1'b0;
    tail("jc1");
    zero_flag = 1'b1;
    fetch("jz1", 8'h83);
    cyc("jz1_t2", 8'h00, 1'b0, K_J, 8'h03);
    zero_flag = 1'b0;
    tail("jz1");
`endif

    // JMP 3, then reset mid-instruction
    fetch("jmp", 8'h63);
    cyc("jmp_t2", 8'h00, 1'b0, K_J, 8'h03);
    rst = 1'b1;
    cyc("mid_rst", 8'h00, 1'b1, K_0, 8'h00);
    rst = 1'b0;
    #1;
    chk("mid_rst_t0", {1'b0, ctl}, {1'b0, K_CO | K_MI});

    // HLT with a nonzero operand so any stray bus drive is visible
    fetch("hlt", 8'hF5);
    cyc("hlt_t2", 8'h00, 1'b1, K_0, 8'h00);
    for (int i = 0; i < 10; i++) cyc("halted", 8'h00, 1'b1, K_HLT, 8'h00);
    rst = 1'b1;
    cyc("hlt_rst", 8'h00, 1'b1, K_0, 8'h00);
    rst = 1'b0;
    #1;
    chk("hlt_rst_t0", {1'b0, ctl}, {1'b0, K_CO | K_MI});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
- Microcoded control sequencer for the 8-bit computer.
- Drives every control line the datapath consumes: A/B registers, ALU, RAM, PC and seven-segment output.
- Replaces manual DIP-switch control.
- Holds the instruction register (IR) and microstep counter, decodes them into a control word, and drives the IR operand onto the shared bus when requested.

Parameters:
- STEPS, 5, microsteps per instruction (0..STEPS-1); minimum 5.
- OPERAND_BITS, 4, width of IR operand field (low bits), driven on bus by IO.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- run  input  1  advance enable; when low, all state holds.
- bus  inout  8  shared main bus; IR loads from it, operand drives onto it.
- load_A  output  1  A register loads from bus (AI).
- load_B  output  1  B register loads from bus (BI).
- write_A  output  1  A register drives bus (AO).
- write_B  output  1  B register drives bus (BO).
- write_ALU  output  1  ALU result drives bus (EO).
- subtract  output  1  ALU subtracts (SU).
- MI  output  1  memory address register loads.
- RO  output  1  RAM drives bus.
- RI  output  1  RAM loads from bus.
- CO  output  1  PC drives bus.
- CE  output  1  PC increments.
- J  output  1  PC loads from bus.
- OI  output  1  display register loads.
- halted  output  1  HLT executed; sequencer frozen.

Behaviour:
- State: ir[7:0], step[$clog2(STEPS)-1:0], halted.
- Reset: ir=0, step=0, halted=0. Reset has priority over run and over mid-instruction state. While rst=1, all control outputs are 0 and the bus is released.
- Control outputs are a combinational decode of (ir[7:4], step, halted). They are stable for the whole cycle, so consumers sample them on the same rising edge.
- Step advance: if run=1 and halted=0, step increments every clk. It wraps from STEPS-1 to 0; no early termination.
- IR load: on a clk edge with II active (fetch step 1), ir <= bus.
- IO: bus = {zeros, ir[OPERAND_BITS-1:0]}; otherwise high-Z.
- Fetch:
  - T0: CO, MI.
  - T1: RO, II, CE.
- Execute, by opcode ir[7:4]:
  - 0000 NOP: none.
  - 0001 LDA: T2 IO,MI; T3 RO,load_A.
  - 0010 ADD: T2 IO,MI; T3 RO,load_B; T4 write_ALU,load_A.
  - 0011 SUB: as ADD, with subtract also asserted in T4.
  - 0100 STA: T2 IO,MI; T3 write_A,RI.
  - 0101 LDI: T2 IO,load_A.
  - 0110 JMP: T2 IO,J.
  - 1110 OUT: T2 write_A,OI.
  - 1111 HLT: T2 sets halted on the edge, then all controls are 0.
  - All other opcodes: NOP.
- Steps beyond an instruction's last action assert nothing.
- Halt state: halted holds until rst. step freezes; the bus is released.
- run=0 mid-instruction: step and ir hold; outputs keep the current step's decode.
- Invariant: no step asserts more than one bus driver (CO, RO, IO, write_A, write_B, write_ALU).

Optional Feature:
- Macro: CONTROL_UNIT_COND_JUMP_EN.
- Enabled:
  - Adds inputs carry_flag and zero_flag, and output FI (flags register load).
  - ADD/SUB T4 additionally assert FI.
  - 0111 JC: T2 IO,J only if carry_flag=1.
  - 1000 JZ: T2 IO,J only if zero_flag=1.
  - Flags are sampled combinationally during T2.
- Disabled: those ports are absent; 0111/1000 decode as NOP.

Decomposition:
- Shared package cpu_pkg:
  - Opcode constants (OP_NOP..OP_HLT, OP_JC, OP_JZ).
  - Control-word bit index constants.
  - Control-word width.
- Sub-module microcode_rom: pure combinational (opcode, step, flags) -> control word.
- control_unit itself owns the registers, halt logic and the bus tri-state, using the existing tri_state_buffer.

Test Plan:
- Reset held 3 cycles, then released with run=1 -> outputs 0 during reset; first cycle after release CO=MI=1, step=0.
- Fetch with bus=0x1E at T1 -> ir=0x1E after the edge. T2 drives bus=0x0E with IO and asserts MI; T3 asserts RO,load_A; step wraps to 0 after T4.
- ir=0x3F (SUB 15) -> T4 asserts write_ALU, load_A and subtract; T3 asserts load_B only.
- run=0 at T2 of STA for 4 cycles -> step stays 2, IO/MI stay asserted; on resume, T3 asserts write_A,RI.
- ir=0xF0 (HLT) -> halted=1 after the T2 edge, all controls 0 and bus Z for 10 cycles; rst -> halted=0, step=0.
- With CONTROL_UNIT_COND_JUMP_EN: ir=0x75 with carry_flag=0 -> no J at T2; with carry_flag=1 -> bus=0x05 and J=1. ADD T4 asserts FI.
